// File: rtl/mips_pkg.sv
// Shared MIPS run-control definitions: FSM state codes, host command codes
// and the default HALT opcode.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } run_state_e;

    typedef enum logic [1:0] {
        CMD_CLEAR = 2'b00,
        CMD_RUN   = 2'b01,
        CMD_STEP  = 2'b10,
        CMD_STOP  = 2'b11
    } run_cmd_e;

    localparam int unsigned NB_HALT_OPCODE = 6;
    localparam logic [NB_HALT_OPCODE-1:0] HALT_OPCODE_DEFAULT = 6'b111111;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Ports: i_clock, i_reset (async, active-high), i_clr, i_inc, o_count.
module sat_counter #(
    parameter int unsigned NB_COUNT = 32
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_clr,
    input  logic                i_inc,
    output logic [NB_COUNT-1:0] o_count
);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_count <= '0;
        end else if (i_clr) begin
            o_count <= '0;
        end else if (i_inc && (o_count != '1)) begin
            o_count <= o_count + NB_COUNT'(1);
        end
    end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run-control for the MIPS pipeline: turns host CLEAR/RUN/STEP/STOP commands
// into the registered pipeline valid, counts executed cycles, drains the pipe
// after a HALT fetch and flags cycle-limit timeouts.
// Ports: i_clock, i_reset (async, active-high), i_cmd_valid, i_cmd,
//        i_cycle_limit (0 = unlimited), i_instr (IF stage instruction),
//        o_valid, o_state, o_cycle_count, o_done, o_timeout.
// Optional: RUN_CTRL_BREAKPOINT_EN adds i_pc, i_bp_addr, i_bp_en; a PC match
//        while running pauses to IDLE.
module pipeline_run_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned NB_INSTR     = 32,
    parameter int unsigned NB_OPCODE    = 6,
    parameter int unsigned NB_CYCLE_CNT = 32,
    parameter int unsigned PIPE_DEPTH   = 5,
    parameter logic [NB_OPCODE-1:0] HALT_OPCODE = NB_OPCODE'(HALT_OPCODE_DEFAULT)
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_cmd_valid,
    input  logic [1:0]              i_cmd,
    input  logic [NB_CYCLE_CNT-1:0] i_cycle_limit,
    input  logic [NB_INSTR-1:0]     i_instr,
`ifdef RUN_CTRL_BREAKPOINT_EN
    input  logic [NB_INSTR-1:0]     i_pc,
    input  logic [NB_INSTR-1:0]     i_bp_addr,
    input  logic                    i_bp_en,
`endif
    output logic                    o_valid,
    output logic [2:0]              o_state,
    output logic [NB_CYCLE_CNT-1:0] o_cycle_count,
    output logic                    o_done,
    output logic                    o_timeout
);

    localparam int unsigned NB_DRAIN  = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam int unsigned NB_CMP    = NB_CYCLE_CNT + 1;
    localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(PIPE_DEPTH - 1);

    run_state_e           state_q, state_d;
    logic [NB_DRAIN-1:0]  drain_q, drain_d;
    logic                 valid_d, done_d, timeout_d;
    logic                 cnt_clr;
    logic                 halt_fetch;
    logic                 limit_hit;
    logic                 bp_hit;
    logic                 unused_instr;

    assign unused_instr = ^i_instr[NB_INSTR-NB_OPCODE-1:0];

    assign halt_fetch = o_valid && (i_instr[NB_INSTR-1 -: NB_OPCODE] == HALT_OPCODE);

    // Widened compare so count+1 cannot wrap at the saturation point.
    assign limit_hit = (i_cycle_limit != '0) &&
                       ((NB_CMP'(o_cycle_count) + NB_CMP'(1)) >= NB_CMP'(i_cycle_limit));

`ifdef RUN_CTRL_BREAKPOINT_EN
    // Armed only after one RUN cycle, so resuming from the breakpoint PC moves on.
    logic bp_armed_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            bp_armed_q <= 1'b0;
        end else begin
            bp_armed_q <= (state_q == ST_RUN);
        end
    end

    assign bp_hit = i_bp_en && bp_armed_q && o_valid && (i_pc == i_bp_addr);
`else
    assign bp_hit = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            drain_q   <= '0;
            o_valid   <= 1'b0;
            o_done    <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            o_valid   <= valid_d;
            o_done    <= done_d;
            o_timeout <= timeout_d;
        end
    end

    // Next-state logic; RUN priority is HALT > limit > breakpoint > STOP.
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        timeout_d = o_timeout;
        cnt_clr   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    case (run_cmd_e'(i_cmd))
                        CMD_RUN:   state_d = ST_RUN;
                        CMD_STEP:  state_d = ST_STEP;
                        CMD_CLEAR: begin
                            cnt_clr   = 1'b1;
                            timeout_d = 1'b0;
                        end
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                if (halt_fetch) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (limit_hit) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else if (bp_hit) begin
                    state_d = ST_IDLE;
                end else if (i_cmd_valid && (run_cmd_e'(i_cmd) == CMD_STOP)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (halt_fetch) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - NB_DRAIN'(1);
                end
            end
            ST_DONE: begin
                if (i_cmd_valid && (run_cmd_e'(i_cmd) == CMD_CLEAR)) begin
                    state_d   = ST_IDLE;
                    cnt_clr   = 1'b1;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_DRAIN);
        done_d  = (state_d == ST_DONE);
    end

    assign o_state = state_q;

    // Counts every edge at which the pipeline was enabled.
    sat_counter #(
        .NB_COUNT (NB_CYCLE_CNT)
    ) u_cycle_cnt (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clr   (cnt_clr),
        .i_inc   (o_valid),
        .o_count (o_cycle_count)
    );

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl: expected output snapshots are queued as
// stimulus is driven and popped when the DUT output is sampled.
module tb_pipeline_run_ctrl;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_STEP  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [1:0] C_CLEAR = 2'b00;
    localparam logic [1:0] C_RUN   = 2'b01;
    localparam logic [1:0] C_STEP  = 2'b10;
    localparam logic [1:0] C_STOP  = 2'b11;
    localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;

    typedef struct packed {
        logic [2:0]  st;
        logic        v;
        logic [31:0] cnt;
        logic        d;
        logic        t;
    } snap_t;

    logic        tb_clock_i;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic [31:0] cycle_limit;
    logic [31:0] instr;
    logic        valid;
    logic [2:0]  state;
    logic [31:0] cycle_count;
    logic        done;
    logic        timeout;
`ifdef RUN_CTRL_BREAKPOINT_EN
    logic [31:0] pc;
    logic [31:0] bp_addr;
    logic        bp_en;
`endif

    int    total;
    int    bad;
    snap_t exp_q[$];
    string nm_q[$];
    snap_t obs;
    snap_t exp_s;
    string nm;

    pipeline_run_ctrl dut (
        .i_clock       (tb_clock_i),
        .i_reset       (rst),
        .i_cmd_valid   (cmd_valid),
        .i_cmd         (cmd),
        .i_cycle_limit (cycle_limit),
        .i_instr       (instr),
`ifdef RUN_CTRL_BREAKPOINT_EN
        .i_pc          (pc),
        .i_bp_addr     (bp_addr),
        .i_bp_en       (bp_en),
`endif
        .o_valid       (valid),
        .o_state       (state),
        .o_cycle_count (cycle_count),
        .o_done        (done),
        .o_timeout     (timeout)
    );

    initial tb_clock_i = 1'b0;
    always #5 tb_clock_i = ~tb_clock_i;

    task automatic push_exp(input string n, input logic [2:0] st, input logic v,
                            input logic [31:0] c, input logic d, input logic t);
        snap_t s;
        s = '{st: st, v: v, cnt: c, d: d, t: t};
        exp_q.push_back(s);
        nm_q.push_back(n);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge tb_clock_i);
            #1;
        end
    endtask

    task automatic send(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        tick(1);
        cmd_valid = 1'b0;
        cmd       = C_CLEAR;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        push_exp("reset_asserted", S_IDLE, 1'b0, 32'd0, 1'b0, 1'b0);
        obs = {state, valid, cycle_count, done, timeout};
        exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
        end
        @(negedge tb_clock_i);
        rst = 1'b0;
        tick(1);
        push_exp("reset_released", S_IDLE, 1'b0, 32'd0, 1'b0, 1'b0);
        obs = {state, valid, cycle_count, done, timeout};
        exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
        end
    endtask

    task automatic test_run_stop;
        send(C_RUN);
        push_exp("run_first_cycle", S_RUN, 1'b1, 32'd0, 1'b0, 1'b0);
        obs = {state, valid, cycle_count, done, timeout};
        exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
        end
        tick(4);
        send(C_STEP);
        push_exp("step_ignored_in_run", S_RUN, 1'b1, 32'd5, 1'b0, 1'b0);
        obs = {state, valid, cycle_count, done, timeout};
        exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
        end
        tick(4);
        send(C_STOP);
        push_exp("stop_after_10", S_IDLE, 1'b0, 32'd10, 1'b0, 1'b0);
        obs = {state, valid, cycle_count, done, timeout};
        exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
        end
        send(C_RUN);
        tick(4);
        send(C_STOP);
        push_exp("resume_5_more", S_IDLE, 1'b0, 32'd15, 1'b0, 1'b0);
        obs = {state, valid, cycle_count, done, timeout};
        exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
        end
    endtask

    task automatic test_step;
        int pulses;
        pulses = 0;
        send(C_CLEAR);
        push_exp("clear_idle", S_IDLE, 1'b0, 32'd0, 1'b0, 1'b0);
        obs = {state, valid, cycle_count, done, timeout};
        exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
        end
        for (int s = 0; s < 3; s++) begin
            send(C_STEP);
            push_exp("step_pulse", S_STEP, 1'b1, 32'(s), 1'b0, 1'b0);
            obs = {state, valid, cycle_count, done, timeout};
            exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
            if (obs !== exp_s) begin
                bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
            end
            if (valid) pulses++;
            for (int k = 0; k < 3; k++) begin
                tick(1);
                if (valid) pulses++;
            end
        end
        total++;
        if (pulses !== 3) begin
            bad++; $display("FAIL step_pulse_count: got %0d want 3", pulses);
        end
        push_exp("step_end", S_IDLE, 1'b0, 32'd3, 1'b0, 1'b0);
        obs = {state, valid, cycle_count, done, timeout};
        exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
        end
    endtask

    task automatic test_halt;
        send(C_CLEAR);
        send(C_RUN);
        tick(6);
        instr = HALT_INSTR;
        tick(1);
        instr = 32'd0;
        push_exp("drain_entry", S_DRAIN, 1'b1, 32'd7, 1'b0, 1'b0);
        obs = {state, valid, cycle_count, done, timeout};
        exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
        end
        send(C_STOP);
        tick(3);
        push_exp("drain_last", S_DRAIN, 1'b1, 32'd11, 1'b0, 1'b0);
        obs = {state, valid, cycle_count, done, timeout};
        exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
        end
        tick(1);
        push_exp("halt_done", S_DONE, 1'b0, 32'd12, 1'b1, 1'b0);
        obs = {state, valid, cycle_count, done, timeout};
        exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
        end
        send(C_RUN);
        push_exp("run_ignored_in_done", S_DONE, 1'b0, 32'd12, 1'b1, 1'b0);
        obs = {state, valid, cycle_count, done, timeout};
        exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
        end
        send(C_CLEAR);
    endtask

    task automatic test_limit;
        int vcnt;
        vcnt = 0;
        cycle_limit = 32'd20;
        send(C_RUN);
        for (int i = 0; i < 60 && valid; i++) begin
            vcnt++;
            tick(1);
        end
        total++;
        if (vcnt !== 20) begin
            bad++; $display("FAIL limit_valid_cycles: got %0d want 20", vcnt);
        end
        push_exp("limit_done", S_DONE, 1'b0, 32'd20, 1'b1, 1'b1);
        obs = {state, valid, cycle_count, done, timeout};
        exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
        end
        send(C_CLEAR);
        push_exp("limit_clear", S_IDLE, 1'b0, 32'd0, 1'b0, 1'b0);
        obs = {state, valid, cycle_count, done, timeout};
        exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
        end
        cycle_limit = 32'd0;
    endtask

    task automatic test_halt_limit_reset;
        cycle_limit = 32'd8;
        send(C_RUN);
        tick(7);
        instr = HALT_INSTR;
        tick(1);
        instr = 32'd0;
        push_exp("halt_beats_limit", S_DRAIN, 1'b1, 32'd8, 1'b0, 1'b0);
        obs = {state, valid, cycle_count, done, timeout};
        exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
        end
        tick(2);
        rst = 1'b1;
        #1;
        push_exp("async_reset_in_drain", S_IDLE, 1'b0, 32'd0, 1'b0, 1'b0);
        obs = {state, valid, cycle_count, done, timeout};
        exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
        end
        @(negedge tb_clock_i);
        rst = 1'b0;
        cycle_limit = 32'd0;
        tick(1);
        push_exp("after_reset_release", S_IDLE, 1'b0, 32'd0, 1'b0, 1'b0);
        obs = {state, valid, cycle_count, done, timeout};
        exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
        end
    endtask

`ifdef RUN_CTRL_BREAKPOINT_EN
    task automatic test_breakpoint;
        bp_addr = 32'h40;
        bp_en   = 1'b1;
        pc      = 32'h0;
        send(C_RUN);
        tick(2);
        pc = 32'h40;
        tick(1);
        push_exp("bp_pause", S_IDLE, 1'b0, 32'd3, 1'b0, 1'b0);
        obs = {state, valid, cycle_count, done, timeout};
        exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
        end
        send(C_RUN);
        tick(1);
        push_exp("bp_resume_skips", S_RUN, 1'b1, 32'd4, 1'b0, 1'b0);
        obs = {state, valid, cycle_count, done, timeout};
        exp_s = exp_q.pop_front(); nm = nm_q.pop_front(); total++;
        if (obs !== exp_s) begin
            bad++; $display("FAIL %s: got %h want %h", nm, obs, exp_s);
        end
        pc = 32'h44;
        send(C_STOP);
        bp_en = 1'b0;
        send(C_CLEAR);
    endtask
`endif

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd         = C_CLEAR;
        cycle_limit = 32'd0;
        instr       = 32'd0;
`ifdef RUN_CTRL_BREAKPOINT_EN
        pc      = 32'd0;
        bp_addr = 32'd0;
        bp_en   = 1'b0;
`endif
        test_reset;
        test_run_stop;
        test_step;
        test_halt;
        test_limit;
        test_halt_limit_reset;
`ifdef RUN_CTRL_BREAKPOINT_EN
        test_breakpoint;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_run_ctrl.md
# pipeline_run_ctrl

Run-control unit that generates the `i_valid` throughput-enable for the MIPS `pipeline` and replaces the constant-high valid used in simulation. It takes run, step, stop and clear commands, counts executed cycles, detects the HALT instruction at fetch, drains the pipeline, and reports completion or cycle-limit timeout. It sits between the debug/host interface and `pipeline`, one instance per core.

## Interface
- `NB_INSTR`, 32, fetched-instruction width
- `NB_OPCODE`, 6, opcode field width (`instr[NB_INSTR-1 -: NB_OPCODE]`)
- `NB_CYCLE_CNT`, 32, cycle counter and limit width
- `PIPE_DEPTH`, 5, drain length in cycles after HALT fetch; must be ≥1
- `HALT_OPCODE`, 6'b111111, opcode that terminates execution
- `i_clock`  in  1  clock, all state updates on rising edge
- `i_reset`  in  1  reset, asynchronous, active-high
- `i_cmd_valid`  in  1  command strobe, one command per asserted cycle
- `i_cmd`  in  2  00 CLEAR, 01 RUN, 10 STEP, 11 STOP
- `i_cycle_limit`  in  NB_CYCLE_CNT  timeout limit; 0 = unlimited; sampled every cycle
- `i_instr`  in  NB_INSTR  instruction currently in IF, from `pipeline`
- `o_valid`  out  1  registered enable to `pipeline.i_valid`
- `o_state`  out  3  current FSM state code
- `o_cycle_count`  out  NB_CYCLE_CNT  cycles with `o_valid`=1, saturating
- `o_done`  out  1  level, high in DONE
- `o_timeout`  out  1  sticky, set when the cycle limit ended execution

## Operation
- States: IDLE(0), RUN(1), STEP(2), DRAIN(3), DONE(4). `o_valid`=1 exactly in RUN, STEP and DRAIN.
- IDLE: RUN→RUN; STEP→STEP; CLEAR→zero counter, clear `o_timeout`, stay IDLE; STOP ignored.
- RUN: STOP→IDLE (paused, counter kept, resumable); HALT fetch→DRAIN; `o_cycle_count`+1 ≥ nonzero limit→DONE with `o_timeout` set; other commands ignored.
- STEP: exactly one valid cycle, then IDLE; HALT fetch in that cycle→DRAIN.
- DRAIN: `o_valid` stays high for exactly PIPE_DEPTH cycles so in-flight instructions retire, then DONE. All commands ignored. Limit is not checked.
- DONE: `o_valid`=0; only CLEAR is honoured (→IDLE, counter zeroed, `o_timeout` cleared).
- HALT fetch = `o_valid`=1 and opcode of `i_instr` == HALT_OPCODE.
- Same-cycle priority in RUN: HALT > limit > STOP. HALT and limit together→DRAIN, `o_timeout` stays 0.
- Counter increments on every edge with `o_valid`=1, including DRAIN cycles, and saturates at all-ones without wrapping.

## Timing
- Reset values: state IDLE, `o_valid`=0, `o_cycle_count`=0, `o_done`=0, `o_timeout`=0, drain counter 0.
- Reset asserted mid-RUN or mid-DRAIN forces all reset values immediately, without waiting for a clock edge.
- Command accepted at edge k → new state and `o_valid` visible from cycle k+1. There is one cycle of latency and no combinational path from inputs to `o_valid`.
- STEP: `o_valid` high for exactly one cycle; counter +1.
- HALT sampled at edge k → DRAIN from k+1, `o_valid` high cycles k+1 … k+PIPE_DEPTH, DONE with `o_valid`=0 at k+PIPE_DEPTH+1.
- Limit L: with RUN from 0, the L-th valid cycle is the last one; DONE, `o_timeout`=1 and `o_valid`=0 on the next cycle, count = L.

## Configuration
- `RUN_CTRL_BREAKPOINT_EN` defined: adds ports `i_pc` (in, NB_INSTR) and `i_bp_addr` (in, NB_INSTR), and `i_bp_en` (in, 1).
  - In RUN, if `i_bp_en` and `i_pc`==`i_bp_addr` with `o_valid`=1, the FSM goes to IDLE (pause). Priority is HALT > limit > breakpoint > STOP.
  - A RUN issued while paused on the breakpoint PC executes at least one cycle before the breakpoint is re-checked.
- Not defined: these ports and the logic are absent, and behaviour is exactly as above.

## Structure
- Shared `mips_pkg`: state encodings, command codes (CMD_CLEAR/RUN/STEP/STOP), default HALT_OPCODE.
- One sub-module: `sat_counter` (parametrised width, inc, clr, saturating), used for the cycle counter. The drain counter is inline.

## Test plan
- Reset, then RUN, then STOP after 10 valid cycles → IDLE, count=10; RUN again for 5 cycles → count=15.
- Three STEP commands spaced 4 cycles apart → three single-cycle `o_valid` pulses, count=3, state IDLE.
- RUN, then `i_instr`=32'hFC000000 at valid cycle 7 → 5 further valid cycles, DONE, count=12, `o_timeout`=0, `o_done`=1.
- `i_cycle_limit`=20, RUN, no HALT → `o_valid` low after 20 cycles, `o_timeout`=1, count=20; CLEAR → IDLE, count=0, flags 0.
- HALT fetched on the same cycle the limit is reached → DRAIN, `o_timeout`=0; `i_reset` pulsed mid-DRAIN → all outputs 0 asynchronously.
- With `RUN_CTRL_BREAKPOINT_EN`, bp_addr=0x40 and the PC reaching 0x40 → IDLE; RUN resumes, and a repeat of PC 0x40 in the first cycle does not stop execution.
